// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions: scoreboard entry layout, forwarding-select
// encoding and the supported range of tracked stages.
package pipe_hazard_ctrl_pkg;

   localparam int MAX_STAGES = 7;
   localparam int MAX_ADDR_W = 16;
   localparam int FWD_W      = 3;

   // fwd_sel value 0 selects the register file; k selects the stage-k result.
   localparam logic [FWD_W-1:0] FWD_REGFILE = 3'd0;
   localparam logic [FWD_W-1:0] FWD_STAGE1  = 3'd1;

   typedef logic [MAX_ADDR_W-1:0] sb_addr_t;

   typedef struct packed {
      logic     valid;
      sb_addr_t rd;
      logic     wr_en;
      logic     is_load;
   } sb_entry_t;

   localparam sb_entry_t SB_BUBBLE = '{valid: 1'b0, rd: '0, wr_en: 1'b0, is_load: 1'b0};

   function automatic logic [FWD_W-1:0] fwd_stage(input int k);
      return FWD_W'(k);
   endfunction

endpackage

// File: rtl/hazard_match.sv
// One read port's view of the scoreboard: youngest matching producer for
// forwarding, plus a flag for a load sitting in stage 1.
module hazard_match
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int NUM_STAGES = 2
)(
   input  sb_addr_t          src_addr,
   input  logic              src_used,
   input  sb_entry_t         sb [NUM_STAGES],
   output logic [FWD_W-1:0]  fwd_sel,
   output logic              load_hit
);

   // Scan oldest to youngest so the youngest match overwrites older ones.
   always_comb begin
      fwd_sel = FWD_REGFILE;
      for (int k = NUM_STAGES; k >= 1; k--) begin
         if (src_used && sb[k-1].valid && sb[k-1].wr_en && (sb[k-1].rd == src_addr)) begin
            fwd_sel = fwd_stage(k);
         end
      end
   end

   assign load_hit = src_used && sb[0].valid && sb[0].wr_en && sb[0].is_load
                     && (sb[0].rd == src_addr);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: destination scoreboard, operand forwarding
// selects, load-use stall, branch flush bubble, NIC freeze and stall counter.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int REG_ADDRESS_LENGTH = 5,
   parameter int NUM_STAGES         = 2,
   parameter int CNT_WIDTH          = 16
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          id_valid,
   input  logic [REG_ADDRESS_LENGTH-1:0] id_ra,
   input  logic [REG_ADDRESS_LENGTH-1:0] id_rb,
   input  logic                          id_ra_used,
   input  logic                          id_rb_used,
   input  logic [REG_ADDRESS_LENGTH-1:0] id_rd,
   input  logic                          id_wr_en,
   input  logic                          id_is_load,
   input  logic                          branch_flush,
   input  logic                          nic_busy,
   output logic                          stall_if,
   output logic                          bubble_ex,
   output logic                          freeze,
   output logic [2:0]                    fwd_sel_a,
   output logic [2:0]                    fwd_sel_b,
   output logic [CNT_WIDTH-1:0]          stall_cycles
);

   sb_entry_t            sb_q [NUM_STAGES];
   sb_entry_t            sb_d [NUM_STAGES];
   sb_entry_t            id_entry;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 use_a, use_b, hit_a, hit_b, load_use;
   sb_addr_t             ra_ext, rb_ext;

   assign ra_ext = sb_addr_t'(id_ra);
   assign rb_ext = sb_addr_t'(id_rb);
   // With no valid instruction in ID its source fields carry no meaning.
   assign use_a  = id_valid && id_ra_used;
   assign use_b  = id_valid && id_rb_used;

   hazard_match #(.NUM_STAGES(NUM_STAGES)) u_match_a (
      .src_addr (ra_ext),
      .src_used (use_a),
      .sb       (sb_q),
      .fwd_sel  (fwd_sel_a),
      .load_hit (hit_a)
   );

   hazard_match #(.NUM_STAGES(NUM_STAGES)) u_match_b (
      .src_addr (rb_ext),
      .src_used (use_b),
      .sb       (sb_q),
      .fwd_sel  (fwd_sel_b),
      .load_hit (hit_b)
   );

   assign load_use = hit_a || hit_b;

   // Freeze dominates, flush beats a load-use stall; nothing asserts in reset.
   always_comb begin
      stall_if  = 1'b0;
      bubble_ex = 1'b0;
      freeze    = 1'b0;
      if (rst) begin
         if (nic_busy) begin
            stall_if = 1'b1;
            freeze   = 1'b1;
         end else if (branch_flush) begin
            bubble_ex = 1'b1;
         end else if (load_use) begin
            stall_if  = 1'b1;
            bubble_ex = 1'b1;
         end
      end
   end

   always_comb begin
      id_entry = SB_BUBBLE;
      if (id_valid && !branch_flush && !load_use) begin
         id_entry.valid   = 1'b1;
         id_entry.rd      = sb_addr_t'(id_rd);
         id_entry.wr_en   = id_wr_en;
         id_entry.is_load = id_is_load;
      end
   end

   assign sb_d[0] = nic_busy ? sb_q[0] : id_entry;

   for (genvar gi = 1; gi < NUM_STAGES; gi++) begin : g_shift
      assign sb_d[gi] = nic_busy ? sb_q[gi] : sb_q[gi-1];
   end

   always_comb begin
      cnt_d = cnt_q;
      if (stall_if && (cnt_q != {CNT_WIDTH{1'b1}})) begin
         cnt_d = cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < NUM_STAGES; k++) begin
            sb_q[k] <= SB_BUBBLE;
         end
         cnt_q <= '0;
      end else begin
         for (int k = 0; k < NUM_STAGES; k++) begin
            sb_q[k] <= sb_d[k];
         end
         cnt_q <= cnt_d;
      end
   end

   assign stall_cycles = cnt_q;

endmodule
